// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared types and helpers for the data-memory port arbiter
package mips_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PEND = 2'd1,
        S_ACK  = 2'd2
    } arb_state_t;

    localparam logic OWNER_CPU  = 1'b0;
    localparam logic OWNER_UART = 1'b1;

    // Counter must hold 0..max_wait inclusive and is never narrower than one bit.
    function automatic int wait_cnt_width(input int max_wait);
        return (max_wait < 1) ? 1 : $clog2(max_wait + 1);
    endfunction

endpackage

// File: rtl/dmem_port_arbiter.sv
// rtl/dmem_port_arbiter.sv - shares the data RAM port between the MEM stage and the UART host
module dmem_port_arbiter
    import mips_pkg::*;
#(
    parameter int BIT_WIDTH  = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int MAX_WAIT   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [BIT_WIDTH-1:0]  cpu_wdata,
    output logic [BIT_WIDTH-1:0]  cpu_rdata,
    output logic                  cpu_stall,
    input  logic                  uart_req,
    input  logic                  uart_we,
    input  logic [ADDR_WIDTH-1:0] uart_addr,
    input  logic [BIT_WIDTH-1:0]  uart_wdata,
    output logic                  uart_busy,
    output logic                  uart_ack,
    output logic [BIT_WIDTH-1:0]  uart_rdata,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [BIT_WIDTH-1:0]  mem_wdata,
    output logic                  mem_we,
    input  logic [BIT_WIDTH-1:0]  mem_rdata
);

    localparam int             WCW        = wait_cnt_width(MAX_WAIT);
    localparam logic [WCW-1:0] WAIT_LIMIT = WCW'(MAX_WAIT);

    arb_state_t            state;
    arb_state_t            next_state;
    logic [WCW-1:0]        wait_cnt;
    logic                  hold_we;
    logic [ADDR_WIDTH-1:0] hold_addr;
    logic [BIT_WIDTH-1:0]  hold_wdata;
    logic                  grant;
    logic                  owner;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            wait_cnt   <= '0;
            hold_we    <= 1'b0;
            hold_addr  <= '0;
            hold_wdata <= '0;
            uart_rdata <= '0;
        end else begin
            state <= next_state;
            if (state == S_IDLE && uart_req) begin
                hold_we    <= uart_we;
                hold_addr  <= uart_addr;
                hold_wdata <= uart_wdata;
                wait_cnt   <= '0;
            end else if (state == S_PEND && !grant && wait_cnt != WAIT_LIMIT) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
            // Read data is captured on the granted cycle; writes keep the last read value.
            if (grant && !hold_we) begin
                uart_rdata <= mem_rdata;
            end
        end
    end

    always_comb begin
        next_state = state;
        grant      = 1'b0;
        owner      = OWNER_CPU;
        case (state)
            S_IDLE: begin
                if (uart_req) begin
                    next_state = S_PEND;
                end
            end
            S_PEND: begin
                grant = !cpu_req || (wait_cnt == WAIT_LIMIT);
                if (grant) begin
                    owner      = OWNER_UART;
                    next_state = S_ACK;
                end
            end
            S_ACK: begin
                next_state = S_IDLE;
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

    // A stall only happens when the CPU actually wanted the port on a forced grant.
    assign cpu_stall = grant & cpu_req;
    assign uart_busy = (state != S_IDLE);
    assign uart_ack  = (state == S_ACK);
    assign cpu_rdata = mem_rdata;

    assign mem_addr  = (owner == OWNER_UART) ? hold_addr  : cpu_addr;
    assign mem_wdata = (owner == OWNER_UART) ? hold_wdata : cpu_wdata;
    assign mem_we    = (owner == OWNER_UART) ? hold_we    : (cpu_req & cpu_we);

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb/tb_dmem_port_arbiter.sv - directed-vector bench for dmem_port_arbiter
module tb_dmem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req;
    logic        cpu_we;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        cpu_stall;
    logic        uart_req;
    logic        uart_we;
    logic [31:0] uart_addr;
    logic [31:0] uart_wdata;
    logic        uart_busy;
    logic        uart_ack;
    logic [31:0] uart_rdata;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic [31:0] mem_rdata;

    logic [31:0] ram [0:255];

    int vectors     = 0;
    int miscompares = 0;
    int ack_count;

    always #5 clk = ~clk;

    dmem_port_arbiter #(
        .BIT_WIDTH (32),
        .ADDR_WIDTH(32),
        .MAX_WAIT  (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .cpu_stall (cpu_stall),
        .uart_req  (uart_req),
        .uart_we   (uart_we),
        .uart_addr (uart_addr),
        .uart_wdata(uart_wdata),
        .uart_busy (uart_busy),
        .uart_ack  (uart_ack),
        .uart_rdata(uart_rdata),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_rdata (mem_rdata)
    );

    assign mem_rdata = ram[mem_addr[9:2]];

    always @(posedge clk) begin
        if (mem_we) ram[mem_addr[9:2]] <= mem_wdata;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one cycle; inputs are then driven and outputs sampled mid-cycle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic idle_inputs();
        cpu_req = 0; cpu_we = 0; cpu_addr = 32'h0; cpu_wdata = 32'h0;
        uart_req = 0; uart_we = 0; uart_addr = 32'h0; uart_wdata = 32'h0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ram[i] <= 32'h0;
        ram[32'h20 >> 2]  <= 32'h12345678;
        ram[32'h100 >> 2] <= 32'h0BADF00D;
        ram[32'h30 >> 2]  <= 32'hDEAD0000;
    end

    initial begin
        idle_inputs();
        rst = 1;

        // 1: reset held two cycles with uart_req high
        uart_req = 1; uart_we = 1; uart_addr = 32'h40; uart_wdata = 32'h00000040;
        for (int i = 0; i < 2; i++) begin
            tick(); settle();
            check("rst_ack", {31'b0, uart_ack}, 32'd0);
            check("rst_busy", {31'b0, uart_busy}, 32'd0);
        end
        check("rst_rdata", uart_rdata, 32'h0);
        check("rst_stall", {31'b0, cpu_stall}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'h0);
        rst = 0;
        tick(); settle();
        check("t1_busy", {31'b0, uart_busy}, 32'd1);
        check("t1_addr", mem_addr, 32'h40);
        uart_req = 0;
        tick(); settle();
        check("t1_ack", {31'b0, uart_ack}, 32'd1);
        tick();

        // 2: CPU idle, UART write
        uart_req = 1; uart_we = 1; uart_addr = 32'h10; uart_wdata = 32'hCAFE0001;
        settle();
        check("t2_c0_stall", {31'b0, cpu_stall}, 32'd0);
        tick(); uart_req = 0; settle();
        check("t2_c1_we", {31'b0, mem_we}, 32'd1);
        check("t2_c1_addr", mem_addr, 32'h10);
        check("t2_c1_wdata", mem_wdata, 32'hCAFE0001);
        check("t2_c1_stall", {31'b0, cpu_stall}, 32'd0);
        tick(); settle();
        check("t2_c2_ack", {31'b0, uart_ack}, 32'd1);
        check("t2_c2_we", {31'b0, mem_we}, 32'd0);
        tick(); settle();
        check("t2_ram", ram[32'h10 >> 2], 32'hCAFE0001);
        check("t2_c3_busy", {31'b0, uart_busy}, 32'd0);

        // 3: CPU loads every cycle, forced grant after MAX_WAIT
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h100;
        uart_req = 1; uart_we = 0; uart_addr = 32'h20;
        tick(); uart_req = 0;
        for (int c = 1; c <= 4; c++) begin
            settle();
            check("t3_wait_addr", mem_addr, 32'h100);
            check("t3_wait_stall", {31'b0, cpu_stall}, 32'd0);
            check("t3_cpu_rdata", cpu_rdata, 32'h0BADF00D);
            tick();
        end
        settle();
        check("t3_c5_stall", {31'b0, cpu_stall}, 32'd1);
        check("t3_c5_addr", mem_addr, 32'h20);
        check("t3_c5_we", {31'b0, mem_we}, 32'd0);
        tick(); settle();
        check("t3_c6_ack", {31'b0, uart_ack}, 32'd1);
        check("t3_c6_rdata", uart_rdata, 32'h12345678);
        check("t3_c6_stall", {31'b0, cpu_stall}, 32'd0);
        tick();

        // 4: CPU stores in cycles 1-2, UART write granted in cycle 3
        idle_inputs();
        uart_req = 1; uart_we = 1; uart_addr = 32'h50; uart_wdata = 32'hA5A50004;
        tick(); uart_req = 0;
        cpu_req = 1; cpu_we = 1; cpu_addr = 32'h60; cpu_wdata = 32'h00000011;
        settle();
        check("t4_c1_addr", mem_addr, 32'h60);
        check("t4_c1_stall", {31'b0, cpu_stall}, 32'd0);
        tick();
        cpu_addr = 32'h64; cpu_wdata = 32'h00000022;
        settle();
        check("t4_c2_wdata", mem_wdata, 32'h00000022);
        tick();
        cpu_req = 0; cpu_we = 0;
        settle();
        check("t4_c3_addr", mem_addr, 32'h50);
        check("t4_c3_we", {31'b0, mem_we}, 32'd1);
        check("t4_c3_stall", {31'b0, cpu_stall}, 32'd0);
        tick(); settle();
        check("t4_c4_ack", {31'b0, uart_ack}, 32'd1);
        tick(); settle();
        check("t4_ram60", ram[32'h60 >> 2], 32'h00000011);
        check("t4_ram64", ram[32'h64 >> 2], 32'h00000022);
        check("t4_ram50", ram[32'h50 >> 2], 32'hA5A50004);

        // 5: uart_req held high; second request only accepted after the ack
        ack_count = 0;
        uart_req = 1; uart_we = 1; uart_addr = 32'h70; uart_wdata = 32'h00000070;
        for (int c = 0; c <= 5; c++) begin
            settle();
            ack_count += uart_ack ? 1 : 0;
            check("t5_ack_pattern", {31'b0, uart_ack}, (c == 2 || c == 5) ? 32'd1 : 32'd0);
            if (c == 1) begin
                check("t5_c1_addr", mem_addr, 32'h70);
                uart_addr = 32'h74; uart_wdata = 32'h00000074;
            end
            if (c == 3) check("t5_c3_busy", {31'b0, uart_busy}, 32'd0);
            if (c == 4) check("t5_c4_addr", mem_addr, 32'h74);
            if (c == 5) uart_req = 0;
            tick();
        end
        check("t5_ack_count", ack_count, 32'd2);
        check("t5_ram74", ram[32'h74 >> 2], 32'h00000074);

        // 6: reset while a UART write to 0x30 is pending
        cpu_req = 1; cpu_we = 1; cpu_addr = 32'h80; cpu_wdata = 32'h00000080;
        uart_req = 1; uart_we = 1; uart_addr = 32'h30; uart_wdata = 32'h0000BEEF;
        tick(); uart_req = 0;
        settle();
        check("t6_pend_busy", {31'b0, uart_busy}, 32'd1);
        rst = 1;
        tick();
        cpu_req = 0; cpu_we = 0;
        settle();
        check("t6_rst_busy", {31'b0, uart_busy}, 32'd0);
        rst = 0;
        for (int c = 0; c < 4; c++) begin
            tick(); settle();
            check("t6_no_ack", {31'b0, uart_ack}, 32'd0);
        end
        check("t6_ram30", ram[32'h30 >> 2], 32'hDEAD0000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
